// File: rtl/axis_frame_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_arbiter_pkg
// Description : Shared state encoding and helper function for the AXI4-Stream
//               frame arbiter and its round-robin selector.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_frame_arbiter_pkg;

  // Arbiter FSM: waiting for a request, or a source owns the sink
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_t;

  // Depth of the output skid stage
  localparam int SKID_DEPTH = 2;

  // Ceiling log2, usable in parameter and port width expressions
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_arbiter_rr
// Description : Combinational round-robin priority encoder. Returns the first
//               requesting index found searching upward from ptr+1, wrapping
//               modulo S_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_arbiter_rr
  import axis_frame_arbiter_pkg::*;
#(
  parameter int S_COUNT = 4,
  parameter int IDX_W   = clog2_f(S_COUNT)
) (
  input  logic [S_COUNT-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_index
);

  int               cand_i;
  logic [IDX_W-1:0] cand_idx;

  // Walk candidates from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_index = '0;
    cand_i    = 0;
    cand_idx  = '0;
    for (int k = S_COUNT; k >= 1; k--) begin
      cand_i   = (int'(ptr) + k) % S_COUNT;
      cand_idx = IDX_W'(cand_i);
      if (req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_index = cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_arbiter
// Description : Shares one AXI4-Stream sink between S_COUNT sources with
//               frame-granular round-robin arbitration. A granted source owns
//               the sink until its tlast beat. Output goes through a 2-entry
//               skid stage so there is no combinational path from s to m.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_arbiter
  import axis_frame_arbiter_pkg::*;
#(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter bit LAST_ENABLE = 1'b1,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]      s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]    s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             grant_valid,
  output logic [clog2_f(S_COUNT)-1:0]      grant_index
);

  localparam int IDX_W = clog2_f(S_COUNT);

  // Beat layout inside a skid entry, MSB to LSB: data, keep, last, id, dest, user
  localparam int USER_LSB = 0;
  localparam int DEST_LSB = USER_LSB + USER_WIDTH;
  localparam int ID_LSB   = DEST_LSB + DEST_WIDTH;
  localparam int LAST_BIT = ID_LSB + ID_WIDTH;
  localparam int KEEP_LSB = LAST_BIT + 1;
  localparam int DATA_LSB = KEEP_LSB + KEEP_WIDTH;
  localparam int BEAT_W   = DATA_LSB + DATA_WIDTH;

  localparam logic [S_COUNT-1:0] SRC_ONE = S_COUNT'(1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;

  logic             rr_gnt_valid;
  logic [IDX_W-1:0] rr_gnt_index;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_last;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [DEST_WIDTH-1:0] sel_dest;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  in_last;
  logic [BEAT_W-1:0]     in_beat;

  logic              accept;
  logic              frame_end;
  logic              pop;
  logic [1:0]        occ;
  logic [1:0]        occ_next;
  logic              room_next;

  logic [BEAT_W-1:0] ent0;
  logic [BEAT_W-1:0] ent1;
  logic              ent0_v;
  logic              ent1_v;

  axis_frame_arbiter_rr #(
    .S_COUNT (S_COUNT),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (s_axis_tvalid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_gnt_valid),
    .gnt_index (rr_gnt_index)
  );

  // Input mux: pick the granted source's beat and sidebands
  always_comb begin
    sel_data = s_axis_tdata[int'(grant_index)*DATA_WIDTH +: DATA_WIDTH];
    sel_keep = s_axis_tkeep[int'(grant_index)*KEEP_WIDTH +: KEEP_WIDTH];
    sel_last = s_axis_tlast[grant_index];
    sel_id   = s_axis_tid[int'(grant_index)*ID_WIDTH +: ID_WIDTH];
    sel_dest = s_axis_tdest[int'(grant_index)*DEST_WIDTH +: DEST_WIDTH];
    sel_user = s_axis_tuser[int'(grant_index)*USER_WIDTH +: USER_WIDTH];
  end

  // Without tlast support every beat is treated as a complete frame
  assign in_last   = LAST_ENABLE ? sel_last : 1'b1;
  assign in_beat   = {sel_data, sel_keep, in_last, sel_id, sel_dest, sel_user};

  // Only the granted source ever sees ready, so any handshake is the granted one
  assign accept    = |(s_axis_tvalid & s_axis_tready);
  assign frame_end = accept & in_last;
  assign pop       = ent0_v & m_axis_tready;

  // Ready for next cycle is only offered if the skid will still have a free slot
  assign occ       = {1'b0, ent0_v} + {1'b0, ent1_v};
  assign occ_next  = occ + {1'b0, accept} - {1'b0, pop};
  assign room_next = (occ_next != 2'(SKID_DEPTH));

  // Arbitration FSM with registered grant and per-source ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= IDX_W'(S_COUNT - 1);
      grant_valid   <= 1'b0;
      grant_index   <= '0;
      s_axis_tready <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          s_axis_tready <= '0;
          if (rr_gnt_valid) begin
            grant_index   <= rr_gnt_index;
            grant_valid   <= 1'b1;
            state         <= ST_ACTIVE;
            s_axis_tready <= room_next ? (SRC_ONE << rr_gnt_index) : '0;
          end
        end
        ST_ACTIVE: begin
          if (frame_end) begin
            rr_ptr        <= grant_index;
            grant_valid   <= 1'b0;
            s_axis_tready <= '0;
            state         <= ST_IDLE;
          end else begin
            s_axis_tready <= room_next ? (SRC_ONE << grant_index) : '0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          grant_valid   <= 1'b0;
          s_axis_tready <= '0;
        end
      endcase
    end
  end

  // Two-entry skid: ent0 drives the sink, ent1 catches the beat in flight on a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0   <= '0;
      ent1   <= '0;
      ent0_v <= 1'b0;
      ent1_v <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (!ent0_v) begin
            ent0   <= in_beat;
            ent0_v <= 1'b1;
          end else begin
            ent1   <= in_beat;
            ent1_v <= 1'b1;
          end
        end
        2'b01: begin
          ent0   <= ent1;
          ent0_v <= ent1_v;
          ent1_v <= 1'b0;
        end
        2'b11: begin
          if (ent1_v) begin
            ent0 <= ent1;
            ent1 <= in_beat;
          end else begin
            ent0 <= in_beat;
          end
        end
        default: begin
          ent0 <= ent0;
        end
      endcase
    end
  end

  assign m_axis_tvalid = ent0_v;
  assign m_axis_tdata  = ent0[DATA_LSB +: DATA_WIDTH];
  assign m_axis_tkeep  = KEEP_ENABLE ? ent0[KEEP_LSB +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
  assign m_axis_tlast  = ent0[LAST_BIT];
  assign m_axis_tid    = ID_ENABLE   ? ent0[ID_LSB +: ID_WIDTH]     : '0;
  assign m_axis_tdest  = DEST_ENABLE ? ent0[DEST_LSB +: DEST_WIDTH] : '0;
  assign m_axis_tuser  = USER_ENABLE ? ent0[USER_LSB +: USER_WIDTH] : '0;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_frame_arbiter
// Description : Self-checking bench for axis_frame_arbiter with a scoreboard
//               of expected sink beats in predicted arbitration order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_arbiter;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         gap;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [3:0]  s_last;
  logic [31:0] s_id;
  logic [31:0] s_dest;
  logic [3:0]  s_user;
  logic [7:0]  m_data;
  logic [0:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [7:0]  m_id;
  logic [7:0]  m_dest;
  logic [0:0]  m_user;
  logic        grant_valid;
  logic [1:0]  grant_index;

  logic [31:0] nl_s_data;
  logic [3:0]  nl_s_valid;
  logic [3:0]  nl_s_ready;
  logic [7:0]  nl_m_data;
  logic [0:0]  nl_m_keep;
  logic        nl_m_valid;
  logic        nl_m_ready;
  logic        nl_m_last;
  logic [7:0]  nl_m_id;
  logic [7:0]  nl_m_dest;
  logic [0:0]  nl_m_user;
  logic        nl_grant_valid;
  logic [1:0]  nl_grant_index;

  beat_t src_q [4][$];
  beat_t exp_q [$];
  int    out_cyc [$];
  int    gnt_log [$];
  int    src_cnt [4];
  int    cyc = 0;
  int    seq;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    sb_en;
  bit    mready_toggle;

  axis_frame_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready), .s_axis_tlast(s_last), .s_axis_tid(s_id),
    .s_axis_tdest(s_dest), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready), .m_axis_tlast(m_last), .m_axis_tid(m_id),
    .m_axis_tdest(m_dest), .m_axis_tuser(m_user),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  axis_frame_arbiter #(.LAST_ENABLE(1'b0)) dut_nl (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(nl_s_data), .s_axis_tkeep(4'hF), .s_axis_tvalid(nl_s_valid),
    .s_axis_tready(nl_s_ready), .s_axis_tlast(4'h0), .s_axis_tid(32'h0),
    .s_axis_tdest(32'h0), .s_axis_tuser(4'h0),
    .m_axis_tdata(nl_m_data), .m_axis_tkeep(nl_m_keep), .m_axis_tvalid(nl_m_valid),
    .m_axis_tready(nl_m_ready), .m_axis_tlast(nl_m_last), .m_axis_tid(nl_m_id),
    .m_axis_tdest(nl_m_dest), .m_axis_tuser(nl_m_user),
    .grant_valid(nl_grant_valid), .grant_index(nl_grant_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Queue a frame on a source; optionally record the beats as expected sink output
  task automatic send_frame(input int src, input int n, input int gap_at,
                            input int gap_len, input bit to_sb);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = {src[1:0], seq[5:0]};
      b.last = (k == n - 1);
      b.user = ^b.data;
      b.gap  = (k == gap_at) ? gap_len : 0;
      src_q[src].push_back(b);
      if (to_sb) exp_q.push_back(b);
      seq++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            src_q[2].size() != 0 || src_q[3].size() != 0 || m_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_in_budget", 32'(k < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Source and sink-ready driver: updates just after each rising edge
  initial begin
    logic [3:0] acc;
    beat_t      b;
    s_valid = '0; s_data = '0; s_last = '0; s_user = '0;
    s_keep  = 4'hF; s_id = 32'hA5A5_A5A5; s_dest = 32'h5A5A_5A5A;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      acc = s_valid & s_ready;
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() == 0) begin
          s_valid[i] = 1'b0;
        end else begin
          b = src_q[i][0];
          if (b.gap > 0) begin
            s_valid[i] = 1'b0;
            b.gap--;
            src_q[i][0] = b;
          end else begin
            s_valid[i]      = 1'b1;
            s_data[i*8 +: 8] = b.data;
            s_last[i]       = b.last;
            s_user[i]       = b.user;
          end
        end
      end
      m_ready = mready_toggle ? ~m_ready : 1'b1;
    end
  end

  // Sink monitor: scoreboard compare, stall stability, grant logging
  initial begin
    bit         prev_stall;
    bit         prev_gv;
    logic [7:0] prev_data;
    logic       prev_last;
    beat_t      e;
    prev_stall = 0; prev_gv = 0; prev_data = '0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        prev_gv    = 0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_valid_held", 32'(m_valid), 32'd1);
          check_eq("stall_data_held", 32'(m_data), 32'(prev_data));
          check_eq("stall_last_held", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
          out_cyc.push_back(cyc);
          if (sb_en) begin
            if (exp_q.size() == 0) begin
              check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
              e = exp_q.pop_front();
              check_eq("sb_data", 32'(m_data), 32'(e.data));
              check_eq("sb_last", 32'(m_last), 32'(e.last));
              check_eq("sb_user", 32'(m_user), 32'(e.user));
              check_eq("tid_zero", 32'(m_id), 32'd0);
              check_eq("tdest_zero", 32'(m_dest), 32'd0);
              check_eq("tkeep_ones", 32'(m_keep), 32'd1);
              src_cnt[m_data[7:6]]++;
            end
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (grant_valid && !prev_gv) gnt_log.push_back(int'(grant_index));
        prev_gv = grant_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         b1;
    int         g1;
    int         c0 [4];
    int         nd;
    logic [7:0] dv [6];
    int         dc [6];
    rst_n = 1'b0; sb_en = 1'b1; mready_toggle = 1'b0; seq = 0;
    for (int i = 0; i < 4; i++) src_cnt[i] = 0;
    nl_s_valid = 4'b0110;
    nl_s_data  = 32'h0022_1100;
    nl_m_ready = 1'b1;

    // Reset state
    #3;
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_grant_valid", 32'(grant_valid), 32'd0);
    check_eq("rst_grant_index", 32'(grant_index), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    #14 rst_n = 1'b1;
    k = 0;
    while (!nl_grant_valid && k < 10) begin @(negedge clk); k++; end
    check_eq("nl_first_grant", 32'(nl_grant_index), 32'd1);
    @(negedge clk);

    // Test 1: src1 and src3 three-beat frames
    b1 = out_cyc.size(); g1 = gnt_log.size();
    send_frame(1, 3, -1, 0, 1'b1);
    send_frame(3, 3, -1, 0, 1'b1);
    wait_drain(100);
    check_eq("t1_beats", 32'(out_cyc.size() - b1), 32'd6);
    if (out_cyc.size() >= b1 + 4) begin
      check_eq("t1_b01_gap", 32'(out_cyc[b1+1] - out_cyc[b1]), 32'd1);
      check_eq("t1_b12_gap", 32'(out_cyc[b1+2] - out_cyc[b1+1]), 32'd1);
      check_eq("t1_frame_gap", 32'(out_cyc[b1+3] - out_cyc[b1+2]), 32'd2);
    end
    check_eq("t1_grants", 32'(gnt_log.size() - g1), 32'd2);
    if (gnt_log.size() >= g1 + 2) begin
      check_eq("t1_grant0", 32'(gnt_log[g1]), 32'd1);
      check_eq("t1_grant1", 32'(gnt_log[g1+1]), 32'd3);
    end

    // Test 2: all sources busy with single-beat frames
    for (int i = 0; i < 4; i++) c0[i] = src_cnt[i];
    for (int r = 0; r < 12; r++)
      for (int s = 0; s < 4; s++) send_frame(s, 1, -1, 0, 1'b1);
    wait_drain(400);
    for (int i = 0; i < 4; i++) check_eq("t2_share", 32'(src_cnt[i] - c0[i]), 32'd12);

    // Test 3: 8-beat frame with a toggling sink
    mready_toggle = 1'b1;
    send_frame(0, 8, -1, 0, 1'b1);
    wait_drain(100);
    mready_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // Test 4: src2 pauses mid-frame while src0 waits
    send_frame(2, 6, 3, 5, 1'b1);
    send_frame(0, 2, -1, 0, 1'b1);
    k = 0;
    while (!(grant_valid && grant_index == 2'd2) && k < 20) begin @(negedge clk); k++; end
    check_eq("t4_grant_seen", 32'(k < 20), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_eq("t4_grant_held", 32'(grant_index), 32'd2);
      check_eq("t4_src0_blocked", 32'(s_ready[0]), 32'd0);
      @(negedge clk);
    end
    wait_drain(100);

    // Test 5: asynchronous reset in the middle of a frame
    sb_en = 1'b0;
    send_frame(1, 10, -1, 0, 1'b0);
    k = 0;
    while (!(grant_valid && grant_index == 2'd1) && k < 20) begin @(negedge clk); k++; end
    check_eq("t5_grant_seen", 32'(k < 20), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("t5_pre_m_valid", 32'(m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_m_valid", 32'(m_valid), 32'd0);
    check_eq("t5_grant_valid", 32'(grant_valid), 32'd0);
    check_eq("t5_s_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    #9 rst_n = 1'b1;
    @(negedge clk);
    g1 = gnt_log.size();
    sb_en = 1'b1;
    send_frame(0, 2, -1, 0, 1'b1);
    send_frame(1, 2, -1, 0, 1'b1);
    wait_drain(100);
    check_eq("t5_grants", 32'(gnt_log.size() - g1), 32'd2);
    if (gnt_log.size() >= g1 + 2) begin
      check_eq("t5_first_src0", 32'(gnt_log[g1]), 32'd0);
      check_eq("t5_then_src1", 32'(gnt_log[g1+1]), 32'd1);
    end

    // Test 6: no-tlast instance alternates src1/src2 with one idle cycle
    nd = 0; k = 0;
    while (nd < 6 && k < 100) begin
      @(negedge clk);
      k++;
      if (nl_m_valid && nl_m_ready) begin
        dv[nd] = nl_m_data;
        dc[nd] = cyc;
        check_eq("t6_last", 32'(nl_m_last), 32'd1);
        nd++;
      end
    end
    check_eq("t6_beats", 32'(nd), 32'd6);
    if (nd == 6) begin
      for (int i = 1; i < 6; i++) begin
        check_eq("t6_alternate", 32'(dv[i]), (dv[i-1] == 8'h11) ? 32'h22 : 32'h11);
        check_eq("t6_spacing", 32'(dc[i] - dc[i-1]), 32'd2);
      end
    end

    check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
